// File: rtl/sd_pkg.sv
// Shared definitions for the SD request arbiter family: command codes,
// arbiter states and the layout of the command status byte.
package sd_pkg;

   localparam logic [7:0] CMD_STATUS    = 8'h01;
   localparam logic [7:0] CMD_TRANSLATE = 8'h02;
   localparam logic [7:0] CMD_CANCEL    = 8'h06;
   localparam logic [7:0] REPLY_NONE    = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ANNOUNCE = 2'd1,
      ST_ACTIVE   = 2'd2
   } arb_state_e;

   // Status byte: {grant_valid, write, any_pending, 2'b0, src[2:0]}
   localparam int STB_GRANT = 7;
   localparam int STB_WRITE = 6;
   localparam int STB_PEND  = 5;

   function automatic logic [7:0] status_byte(input logic       grant,
                                              input logic       wr,
                                              input logic       pend,
                                              input logic [2:0] src);
      logic [7:0] b;
      b            = 8'h00;
      b[STB_GRANT] = grant;
      b[STB_WRITE] = wr;
      b[STB_PEND]  = pend;
      b[2:0]       = src;
      return b;
   endfunction

endpackage

// File: rtl/sd_rr_pick.sv
// Combinational round-robin picker: first set bit of pending_i strictly
// after last_i, wrapping modulo N.
module sd_rr_pick #(
   parameter int N    = 8,
   parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    pending_i,
   input  logic [IDXW-1:0] last_i,
   output logic            valid_o,
   output logic [IDXW-1:0] idx_o
);

   logic [IDXW-1:0] cand;

   always_comb begin
      valid_o = 1'b0;
      idx_o   = last_i;
      cand    = last_i;
      // Offset 1 first so the last winner is considered last.
      for (int k = 1; k <= N; k++) begin
         cand = IDXW'((int'(last_i) + k) % N);
         if (!valid_o && pending_i[cand]) begin
            valid_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/sd_req_arb.sv
// Multi-source SD sector request arbiter: round-robin grant, MCU byte-serial
// announce/translate handshake, single start pulse to the SD engine.
module sd_req_arb
   import sd_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter int SECW    = 32,
   parameter int TIMEOUT = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_SRC-1:0]      rstart,
   input  logic [NUM_SRC-1:0]      wstart,
   input  logic [NUM_SRC*SECW-1:0] src_sector,
   input  logic                    data_strobe,
   input  logic                    data_start,
   input  logic [7:0]              data_in,
   output logic [7:0]              data_out,
   output logic                    irq,
   input  logic                    iack,
   output logic                    sd_start,
   output logic                    sd_write,
   output logic [SECW-1:0]         sd_sector,
   input  logic                    sd_done,
   output logic [NUM_SRC-1:0]      src_busy,
   output logic [NUM_SRC-1:0]      src_done,
   output logic [NUM_SRC-1:0]      src_err
);

   localparam int         IDXW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int         NB       = SECW / 8;
   localparam int         TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [3:0] NB_CNT   = 4'(NB);
   localparam logic [3:0] LAST_CNT = 4'(NB - 1);

   arb_state_e         state_q, state_d;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [IDXW-1:0]    last_q, last_d;
   logic [IDXW-1:0]    src_q, src_d;
   logic               dir_q, dir_d;
   logic [SECW-1:0]    log_sec_q, log_sec_d;
   logic [SECW-1:0]    sd_sec_q, sd_sec_d;
   logic               irq_q, irq_d;
   logic [7:0]         cmd_q, cmd_d;
   logic               cmd_ok_q, cmd_ok_d;
   logic [3:0]         byte_cnt_q, byte_cnt_d;
   logic [7:0]         dout_q, dout_d;
   logic               start_q, start_d;
   logic [NUM_SRC-1:0] done_q, done_d;
   logic [NUM_SRC-1:0] err_q, err_d;
   logic [TW-1:0]      tmo_q, tmo_d;
   logic [NUM_SRC-1:0] rstart_q, wstart_q;
   logic               req_dir_q [NUM_SRC];
   logic [SECW-1:0]    req_sec_q [NUM_SRC];

   logic [NUM_SRC-1:0] rise_r, rise_w, busy, accept;
   logic               grant_valid, pick_valid;
   logic [IDXW-1:0]    pick_idx;
   logic               cmd_start, cmd_byte, cancel_req, tr_byte, tr_last, tmo_hit;
   logic [7:0]         stat_byte, sec_byte;

   assign rise_r      = rstart & ~rstart_q;
   assign rise_w      = wstart & ~wstart_q;
   assign grant_valid = (state_q != ST_IDLE);

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++)
         busy[i] = pending_q[i] | (grant_valid && (src_q == IDXW'(i)));
   end

   assign accept     = (rise_r | rise_w) & ~busy;
   assign cmd_start  = data_strobe & data_start;
   assign cmd_byte   = data_strobe & ~data_start;
   assign cancel_req = cmd_start && (data_in == CMD_CANCEL) && grant_valid;
   assign tr_byte    = cmd_byte && cmd_ok_q && (state_q == ST_ANNOUNCE) && (byte_cnt_q < NB_CNT);
   assign tr_last    = tr_byte && (byte_cnt_q == LAST_CNT);
   assign tmo_hit    = (TIMEOUT > 0) && (state_q == ST_ACTIVE) && (tmo_q == TW'(TIMEOUT - 1));
   assign stat_byte  = status_byte(grant_valid, dir_q, |pending_q, 3'(src_q));

   always_comb begin
      sec_byte = 8'h00;
      if (byte_cnt_q < NB_CNT)
         sec_byte = 8'(log_sec_q >> (8 * (NB - 1 - int'(byte_cnt_q))));
   end

   sd_rr_pick #(.N(NUM_SRC), .IDXW(IDXW)) u_pick (
      .pending_i (pending_q),
      .last_i    (last_q),
      .valid_o   (pick_valid),
      .idx_o     (pick_idx)
   );

   always_comb begin
      // NOTE: every next-state variable takes its held value first, so no path
      // through the decode below can leave one unassigned and infer a latch.
      state_d    = state_q;
      pending_d  = pending_q | accept;
      last_d     = last_q;
      src_d      = src_q;
      dir_d      = dir_q;
      log_sec_d  = log_sec_q;
      sd_sec_d   = sd_sec_q;
      irq_d      = irq_q & ~iack;
      cmd_d      = cmd_q;
      cmd_ok_d   = cmd_ok_q;
      byte_cnt_d = byte_cnt_q;
      dout_d     = dout_q;
      start_d    = 1'b0;
      done_d     = '0;
      err_d      = accept & rise_r & rise_w;
      tmo_d      = tmo_q;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               pending_d[pick_idx] = 1'b0;
               src_d               = pick_idx;
               dir_d               = req_dir_q[pick_idx];
               log_sec_d           = req_sec_q[pick_idx];
               irq_d               = 1'b1;
               cmd_ok_d            = 1'b0;
               state_d             = ST_ANNOUNCE;
            end
         end
         ST_ANNOUNCE: begin
            if (tr_last) begin
               start_d = 1'b1;
               tmo_d   = '0;
               state_d = ST_ACTIVE;
            end else if (cancel_req) begin
               err_d[src_q] = 1'b1;
               last_d       = src_q;
               state_d      = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            tmo_d = tmo_q + 1'b1;
            // Completion outranks a cancel arriving in the same cycle.
            if (sd_done) begin
               done_d[src_q] = 1'b1;
               last_d        = src_q;
               state_d       = ST_IDLE;
            end else if (tmo_hit) begin
               err_d[src_q] = 1'b1;
               state_d      = ST_IDLE;
            end else if (cancel_req) begin
               err_d[src_q] = 1'b1;
               last_d       = src_q;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (cmd_start) begin
         cmd_d      = data_in;
         byte_cnt_d = '0;
         cmd_ok_d   = (data_in == CMD_TRANSLATE) && (state_q == ST_ANNOUNCE);
         dout_d     = stat_byte;
      end else if (cmd_byte) begin
         if (byte_cnt_q != 4'hF)
            byte_cnt_d = byte_cnt_q + 4'd1;
         if (tr_byte)
            sd_sec_d = (sd_sec_q << 8) | SECW'(data_in);
         case (cmd_q)
            CMD_STATUS:    dout_d = sec_byte;
            CMD_TRANSLATE: dout_d = (cmd_ok_q && (byte_cnt_q >= LAST_CNT)) ?
                                    {7'd0, state_d == ST_ACTIVE} : REPLY_NONE;
            default:       dout_d = REPLY_NONE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the values
      // all other registers held before this edge, independent of order.
      if (rst) begin
         state_q    <= ST_IDLE;
         pending_q  <= '0;
         last_q     <= IDXW'(NUM_SRC - 1);
         src_q      <= '0;
         dir_q      <= 1'b0;
         log_sec_q  <= '0;
         sd_sec_q   <= '0;
         irq_q      <= 1'b0;
         cmd_q      <= 8'h00;
         cmd_ok_q   <= 1'b0;
         byte_cnt_q <= 4'hF;
         dout_q     <= 8'h00;
         start_q    <= 1'b0;
         done_q     <= '0;
         err_q      <= '0;
         tmo_q      <= '0;
         rstart_q   <= '0;
         wstart_q   <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         last_q     <= last_d;
         src_q      <= src_d;
         dir_q      <= dir_d;
         log_sec_q  <= log_sec_d;
         sd_sec_q   <= sd_sec_d;
         irq_q      <= irq_d;
         cmd_q      <= cmd_d;
         cmd_ok_q   <= cmd_ok_d;
         byte_cnt_q <= byte_cnt_d;
         dout_q     <= dout_d;
         start_q    <= start_d;
         done_q     <= done_d;
         err_q      <= err_d;
         tmo_q      <= tmo_d;
         rstart_q   <= rstart;
         wstart_q   <= wstart;
      end
   end

   // NOTE: the per-source request store has no reset; an entry is only read
   // once its pending bit, which is reset, has been set by a capture.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (accept[i]) begin
            req_dir_q[i] <= ~rise_r[i];
            req_sec_q[i] <= src_sector[i*SECW +: SECW];
         end
      end
   end

   assign data_out  = dout_q;
   assign irq       = irq_q;
   assign sd_start  = start_q;
   assign sd_write  = dir_q;
   assign sd_sector = sd_sec_q;
   assign src_busy  = busy;
   assign src_done  = done_q;
   assign src_err   = err_q;

endmodule

// File: tb/tb_sd_req_arb.sv
// Directed bench for sd_req_arb: command-channel vector table for a single
// read, then hand-written round-robin, cancel, conflict, timeout and reset cases.
module tb_sd_req_arb;
   import sd_pkg::*;

   localparam int N  = 8;
   localparam int SW = 32;

   logic          clk, rst;
   logic [N-1:0]  rstart, wstart;
   logic [N*SW-1:0] src_sector;
   logic          data_strobe, data_start;
   logic [7:0]    data_in, data_out;
   logic          irq, iack, sd_start, sd_write, sd_done;
   logic [SW-1:0] sd_sector;
   logic [N-1:0]  src_busy, src_done, src_err;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic       start;
      logic [7:0] din;
      logic [7:0] dout;
      logic       sd_start;
   } cmd_vec_t;

   cmd_vec_t vecs [13];

   sd_req_arb #(.NUM_SRC(N), .SECW(SW), .TIMEOUT(100)) dut (
      .clk         (clk),
      .rst         (rst),
      .rstart      (rstart),
      .wstart      (wstart),
      .src_sector  (src_sector),
      .data_strobe (data_strobe),
      .data_start  (data_start),
      .data_in     (data_in),
      .data_out    (data_out),
      .irq         (irq),
      .iack        (iack),
      .sd_start    (sd_start),
      .sd_write    (sd_write),
      .sd_sector   (sd_sector),
      .sd_done     (sd_done),
      .src_busy    (src_busy),
      .src_done    (src_done),
      .src_err     (src_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_sec(input int i, input logic [31:0] v);
      src_sector[i*SW +: SW] = v;
   endtask

   task automatic req(input logic [N-1:0] rm, input logic [N-1:0] wm);
      rstart = rm;
      wstart = wm;
      tick(1);
      rstart = '0;
      wstart = '0;
   endtask

   task automatic send(input logic s, input logic [7:0] d);
      data_strobe = 1'b1;
      data_start  = s;
      data_in     = d;
      tick(1);
      data_strobe = 1'b0;
      data_start  = 1'b0;
      data_in     = 8'h00;
   endtask

   task automatic wait_irq();
      for (int k = 0; k < 8 && irq !== 1'b1; k++)
         tick(1);
      check("irq_rise", 32'(irq), 32'd1);
   endtask

   task automatic grant_to_active(input int src, input logic wr, input logic [31:0] phys);
      logic [7:0] b8;
      logic [2:0] s3;
      s3 = 3'(src);
      wait_irq();
      iack = 1'b1;
      tick(1);
      iack = 1'b0;
      check("irq_ack", 32'(irq), 32'd0);
      send(1'b1, CMD_TRANSLATE);
      check("grant_status", 32'(data_out & 8'hC7), 32'({1'b1, wr, 3'b000, s3}));
      for (int b = 0; b < 4; b++) begin
         b8 = phys[(3 - b)*8 +: 8];
         send(1'b0, b8);
      end
      check("start_pulse", 32'(sd_start), 32'd1);
      check("sd_sector", sd_sector, phys);
      check("sd_write", 32'(sd_write), 32'(wr));
      check("translate_reply", 32'(data_out), 32'h01);
   endtask

   task automatic finish_done(input int src);
      sd_done = 1'b1;
      tick(1);
      sd_done = 1'b0;
      check("src_done", 32'(src_done), 32'(8'(1) << src));
      check("busy_cleared", 32'(src_busy[src]), 32'd0);
   endtask

   initial begin
      int hit;
      vecs[0]  = '{1'b1, 8'h01, 8'h82, 1'b0};
      vecs[1]  = '{1'b0, 8'h00, 8'h00, 1'b0};
      vecs[2]  = '{1'b0, 8'h00, 8'h00, 1'b0};
      vecs[3]  = '{1'b0, 8'h00, 8'h12, 1'b0};
      vecs[4]  = '{1'b0, 8'h00, 8'h34, 1'b0};
      vecs[5]  = '{1'b0, 8'h00, 8'h00, 1'b0};
      vecs[6]  = '{1'b1, 8'h02, 8'h82, 1'b0};
      vecs[7]  = '{1'b0, 8'h00, 8'hFF, 1'b0};
      vecs[8]  = '{1'b0, 8'hAB, 8'hFF, 1'b0};
      vecs[9]  = '{1'b0, 8'hCD, 8'hFF, 1'b0};
      vecs[10] = '{1'b0, 8'hEF, 8'h01, 1'b1};
      vecs[11] = '{1'b1, 8'h05, 8'h82, 1'b0};
      vecs[12] = '{1'b0, 8'h00, 8'hFF, 1'b0};

      rst = 1'b1; rstart = '0; wstart = '0; src_sector = '0;
      data_strobe = 1'b0; data_start = 1'b0; data_in = 8'h00;
      iack = 1'b0; sd_done = 1'b0;
      tick(2);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_sd_start", 32'(sd_start), 32'd0);
      check("rst_busy", 32'(src_busy), 32'd0);
      check("rst_done_err", 32'({src_done, src_err}), 32'd0);
      rst = 1'b0;
      tick(1);

      // Single read from source 2
      set_sec(2, 32'h0000_1234);
      req(8'h04, 8'h00);
      check("capture_busy", 32'(src_busy), 32'h04);
      check("capture_no_irq", 32'(irq), 32'd0);
      tick(1);
      check("grant_irq", 32'(irq), 32'd1);
      for (int v = 0; v < 13; v++) begin
         send(vecs[v].start, vecs[v].din);
         check($sformatf("vec%0d_data_out", v), 32'(data_out), 32'(vecs[v].dout));
         check($sformatf("vec%0d_sd_start", v), 32'(sd_start), 32'(vecs[v].sd_start));
      end
      check("single_sector", sd_sector, 32'h00AB_CDEF);
      check("single_write", 32'(sd_write), 32'd0);
      finish_done(2);
      check("single_busy_all", 32'(src_busy), 32'd0);
      tick(1);
      check("done_one_cycle", 32'(src_done), 32'd0);

      // Cancel in ANNOUNCE, then round-robin 6, 1, 3 with last_grant = 3
      set_sec(3, 32'h3333_0003);
      req(8'h08, 8'h00);
      wait_irq();
      iack = 1'b1; tick(1); iack = 1'b0;
      req(8'h42, 8'h00);
      send(1'b1, CMD_CANCEL);
      check("cancel_err", 32'(src_err), 32'h08);
      check("cancel_no_start", 32'(sd_start), 32'd0);
      check("cancel_status", 32'(data_out), 32'hA3);
      rstart = 8'h08;
      tick(1);
      rstart = '0;
      check("regrant_irq", 32'(irq), 32'd1);
      check("rr_busy", 32'(src_busy), 32'h4A);
      grant_to_active(6, 1'b0, 32'h0600_0006);
      finish_done(6);
      grant_to_active(1, 1'b0, 32'h0100_0001);
      finish_done(1);
      grant_to_active(3, 1'b0, 32'h0300_0003);
      finish_done(3);

      // Simultaneous read and write edges on source 0
      req(8'h01, 8'h01);
      check("conflict_err", 32'(src_err), 32'h01);
      grant_to_active(0, 1'b0, 32'h0000_0100);
      finish_done(0);

      // Timeout after 100 ACTIVE cycles on a write from source 4
      req(8'h00, 8'h10);
      grant_to_active(4, 1'b1, 32'h0444_4444);
      hit = 0;
      for (int k = 1; k <= 150 && hit == 0; k++) begin
         tick(1);
         if (src_err !== '0) hit = k;
      end
      check("timeout_cycle", 32'(hit), 32'd100);
      check("timeout_err", 32'(src_err), 32'h10);
      check("timeout_idle", 32'(src_busy), 32'd0);

      // sd_done and CANCEL in the same cycle: done wins
      req(8'h20, 8'h00);
      grant_to_active(5, 1'b0, 32'h0555_0005);
      sd_done = 1'b1; data_strobe = 1'b1; data_start = 1'b1; data_in = CMD_CANCEL;
      tick(1);
      sd_done = 1'b0; data_strobe = 1'b0; data_start = 1'b0; data_in = 8'h00;
      check("race_done", 32'(src_done), 32'h20);
      check("race_no_err", 32'(src_err), 32'd0);

      // Reset while ACTIVE with another source pending
      req(8'h00, 8'h80);
      grant_to_active(7, 1'b1, 32'h0777_0007);
      req(8'h01, 8'h00);
      check("pre_rst_busy", 32'(src_busy), 32'h81);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("rst_act_busy", 32'(src_busy), 32'd0);
      check("rst_act_irq", 32'(irq), 32'd0);
      check("rst_act_write", 32'(sd_write), 32'd0);
      check("rst_act_sector", sd_sector, 32'd0);
      tick(2);
      check("rst_stays_idle", 32'(src_busy), 32'd0);
      req(8'h04, 8'h00);
      grant_to_active(2, 1'b0, 32'h0222_2222);
      finish_done(2);

      // Reset on the cycle of the final TRANSLATE byte: no start pulse
      req(8'h02, 8'h00);
      wait_irq();
      send(1'b1, CMD_TRANSLATE);
      for (int b = 0; b < 3; b++) send(1'b0, 8'h11);
      data_strobe = 1'b1; data_start = 1'b0; data_in = 8'h22; rst = 1'b1;
      tick(1);
      data_strobe = 1'b0; data_in = 8'h00; rst = 1'b0;
      check("rst_last_no_start", 32'(sd_start), 32'd0);
      check("rst_last_irq", 32'(irq), 32'd0);
      tick(1);
      check("rst_last_still_no_start", 32'(sd_start), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
